// File: rtl/morse_pkg.sv
// Shared Morse timing constants and FSM state type, used by both the encoder and decoder sides.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_e;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
  localparam logic [2:0] MAX_LEN          = 3'd5;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: counts 0..UNIT_TICKS-1 and flags the last cycle of each Morse unit.
module morse_unit_timer #(
  parameter int unsigned UNIT_TICKS = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic unit_tick
);

  localparam int unsigned CW = $clog2(UNIT_TICKS);
  localparam logic [CW-1:0] LAST = CW'(UNIT_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    unit_tick = (cnt_q == LAST);
    if (restart || unit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: one captured character at a time, keyed out with standard unit timing.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] len,
  input  logic [4:0] pattern,
  input  logic       word_end,
  output logic       key,
  output logic       ready,
  output logic       done
);

  state_e     state_q, state_d;
  logic [4:0] pattern_q, pattern_d;
  logic       word_end_q, word_end_d;
  logic [2:0] elem_q, elem_d;
  logic [2:0] unit_q, unit_d;
  logic       key_q, key_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  logic [2:0] len_c;
  logic [7:0] pat_ext;
  logic       cur_dash;
  logic [2:0] target_units;
  logic       unit_tick;
  logic       state_end;
  logic       restart;

  assign len_c    = clamp_len(len);
  // Widened so any 3-bit element index selects a defined bit.
  assign pat_ext  = {3'b000, pattern_q};
  assign cur_dash = pat_ext[elem_q];

  always_comb begin
    target_units = DOT_UNITS;
    unique case (state_q)
      IDLE:  target_units = DOT_UNITS;
      MARK:  target_units = cur_dash ? DASH_UNITS : DOT_UNITS;
      SPACE: target_units = ELEM_GAP_UNITS;
      GAP:   target_units = word_end_q ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
      default: target_units = DOT_UNITS;
    endcase
  end

  assign state_end = (state_q != IDLE) && unit_tick && (unit_q == target_units - 3'd1);
  // Holding the prescaler cleared in IDLE makes every state start on a full unit.
  assign restart   = (state_q == IDLE) || state_end;

  morse_unit_timer #(
    .UNIT_TICKS(UNIT_TICKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .unit_tick(unit_tick)
  );

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    word_end_d = word_end_q;
    elem_d     = elem_q;
    done_d     = 1'b0;

    if (restart) begin
      unit_d = 3'd0;
    end else if (unit_tick) begin
      unit_d = unit_q + 3'd1;
    end else begin
      unit_d = unit_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pattern_d  = pattern;
          word_end_d = word_end;
          if (len_c != 3'd0) begin
            state_d = MARK;
            elem_d  = len_c - 3'd1;
          end else begin
            state_d = GAP;
            elem_d  = 3'd0;
          end
        end
      end
      MARK: begin
        if (state_end) begin
          if (elem_q != 3'd0) begin
            state_d = SPACE;
            elem_d  = elem_q - 3'd1;
          end else begin
            state_d = GAP;
          end
        end
      end
      SPACE: begin
        if (state_end) begin
          state_d = MARK;
        end
      end
      GAP: begin
        if (state_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    key_d   = (state_d == MARK);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pattern_q  <= 5'd0;
      word_end_q <= 1'b0;
      elem_q     <= 3'd0;
      unit_q     <= 3'd0;
      key_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      word_end_q <= word_end_d;
      elem_q     <= elem_d;
      unit_q     <= unit_d;
      key_q      <= key_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign key   = key_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: per-cycle expected key/ready/done from a waveform model.
module tb_morse_encoder;

  localparam int unsigned U = 4;

  typedef struct packed {
    logic key;
    logic ready;
    logic done;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] len;
  logic [4:0] pattern;
  logic       word_end;
  logic       key;
  logic       ready;
  logic       done;

  int   checks;
  int   failures;
  int   cyc;
  int   pushed_upto;
  logic last_ready;
  logic run;
  exp_t sb[$];

  morse_encoder #(
    .UNIT_TICKS(U)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .pattern (pattern),
    .word_end(word_end),
    .key     (key),
    .ready   (ready),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (run) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty t=%0t got key/ready/done=%b%b%b required an expected entry",
                 $time, key, ready, done);
      end else begin
        e = sb.pop_front();
        if ({key, ready, done} !== {e.key, e.ready, e.done}) begin
          failures++;
          if (failures <= 20) begin
            $display("FAIL sb_cycle t=%0t key/ready/done got %b%b%b required %b%b%b",
                     $time, key, ready, done, e.key, e.ready, e.done);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  function automatic void push_entry(input logic k, input logic r, input logic d);
    exp_t e;
    e.key = k;
    e.ready = r;
    e.done = d;
    sb.push_back(e);
    pushed_upto++;
    last_ready = r;
  endfunction

  // Expected waveform of one character, straight from the unit rules.
  task automatic push_char(input logic [2:0] l, input logic [4:0] p, input logic w);
    int n;
    n = (l > 3'd5) ? 5 : int'(l);
    for (int i = n - 1; i >= 0; i--) begin
      repeat ((p[i] ? 3 : 1) * U) push_entry(1'b1, 1'b0, 1'b0);
      if (i > 0) repeat (U) push_entry(1'b0, 1'b0, 1'b0);
    end
    repeat ((w ? 7 : 3) * U) push_entry(1'b0, 1'b0, 1'b0);
  endtask

  // Drive inputs for the current cycle and extend the expectation by one cycle if needed.
  task automatic step(input logic s, input logic [2:0] l, input logic [4:0] p, input logic w);
    start = s;
    len = l;
    pattern = p;
    word_end = w;
    if (pushed_upto == cyc) begin
      if (last_ready && s) begin
        push_char(l, p, w);
      end else begin
        push_entry(1'b0, 1'b1, !last_ready);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sb_init();
    @(posedge clk);
    sb.delete();
    cyc = 0;
    pushed_upto = 0;
    sb.push_back(exp_t'(3'b010));
    last_ready = 1'b1;
    run = 1'b1;
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(pushed_upto == cyc && last_ready) && n < 400) begin
      step(1'b0, 3'd0, 5'd0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout: got %0d cycles required < 400", n);
    end
    repeat (2) step(1'b0, 3'd0, 5'd0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    pushed_upto = 0;
    last_ready = 1'b1;
    run = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    len = 3'd0;
    pattern = 5'd0;
    word_end = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_key", key, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sb_init();

    step(1'b1, 3'd2, 5'b00001, 1'b0);  // 'A'
    drain();
    step(1'b1, 3'd7, 5'b11111, 1'b0);  // '0', clamped length
    drain();
    step(1'b1, 3'd0, 5'b10101, 1'b1);  // word space
    drain();
    repeat (60) step(1'b1, 3'd1, 5'b00000, 1'b0);  // 'E' back-to-back
    drain();

    // Busy start in the middle of a dash must be ignored.
    step(1'b1, 3'd1, 5'b00001, 1'b0);
    repeat (6) step(1'b0, 3'd0, 5'd0, 1'b0);
    step(1'b1, 3'd5, 5'b10110, 1'b1);
    drain();

    repeat (1500) begin
      logic s;
      if (pushed_upto == cyc && last_ready) s = ($urandom_range(0, 2) == 0);
      else s = ($urandom_range(0, 7) == 0);
      step(s, 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset at cycle 6 of a dash.
    run = 1'b0;
    sb.delete();
    start = 1'b1;
    len = 3'd1;
    pattern = 5'b00001;
    word_end = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_key", key, 1'b1);
    chk("pre_reset_ready", ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_reset_key", key, 1'b0);
    chk("async_reset_ready", ready, 1'b1);
    chk("async_reset_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sb_init();
    step(1'b1, 3'd2, 5'b00001, 1'b0);
    drain();
    step(1'b1, 3'd3, 5'b00101, 1'b1);
    drain();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
